// File: rtl/soln_dispense_seq_if.sv
// Control and status bundle for the solution dispense sequencer.
// The master side issues runs and durations. The slave side drives the valves and status.
interface soln_dispense_seq_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] t_soln2;
    logic [CNT_W-1:0] t_soln3;
    logic [CNT_W-1:0] t_soln1;
    logic [CNT_W-1:0] t_settle;
    logic [CNT_W-1:0] t_collect;
    logic             valve_soln1;
    logic             valve_soln2;
    logic             valve_soln3;
    logic             valve_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [2:0]       phase;

    modport master (
        output start, abort, t_soln2, t_soln3, t_soln1, t_settle, t_collect,
        input  valve_soln1, valve_soln2, valve_soln3, valve_out, busy, done, aborted, phase
    );

    modport slave (
        input  start, abort, t_soln2, t_soln3, t_soln1, t_settle, t_collect,
        output valve_soln1, valve_soln2, valve_soln3, valve_out, busy, done, aborted, phase
    );
endinterface

// File: rtl/soln_dispense_seq.sv
// Timed valve sequencer. It runs S2 -> S3 -> S1 -> SETTLE -> COLLECT -> DONE.
// Phases with a zero duration are skipped, and every output is registered.
module soln_dispense_seq #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    soln_dispense_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S2      = 3'd1,
        S3      = 3'd2,
        S1      = 3'd3,
        SETTLE  = 3'd4,
        COLLECT = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int NPH = 5;  // timed phases, indexed by state code minus one

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shd_q  [NPH];
    logic [CNT_W-1:0] dur_in [NPH];
    logic [CNT_W-1:0] dur    [NPH];
    logic [2:0]       search_from;
    state_t           nz_state;
    logic [CNT_W-1:0] nz_dur;
    logic             accept;
    logic             aborted_d;
    logic             v1_q, v2_q, v3_q, vo_q, busy_q, done_q, aborted_q;

    // In IDLE the live inputs are used, because the first phase is chosen on the accepting edge.
    always_comb begin
        dur_in[0] = bus.t_soln2;
        dur_in[1] = bus.t_soln3;
        dur_in[2] = bus.t_soln1;
        dur_in[3] = bus.t_settle;
        dur_in[4] = bus.t_collect;
        for (int k = 0; k < NPH; k++) begin
            dur[k] = (state_q == IDLE) ? dur_in[k] : shd_q[k];
        end
    end

    // Find the first later phase with a nonzero duration. Fall through to DONE if there is none.
    always_comb begin
        search_from = (state_q == IDLE) ? 3'd0 : 3'(state_q);
        nz_state    = DONE;
        nz_dur      = '0;
        for (int k = NPH - 1; k >= 0; k--) begin
            if (k >= int'(search_from) && dur[k] != '0) begin
                nz_state = state_t'(3'(k + 1));
                nz_dur   = dur[k];
            end
        end
    end

    assign accept = (state_q == IDLE) && bus.start && !bus.abort;

    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        if (state_q != IDLE && bus.abort) begin
            state_d   = IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = nz_state;
                        cnt_d   = nz_dur;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    // The counter is loaded with the full duration and the phase ends at 1,
                    // so the all-ones duration never wraps.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = nz_state;
                        cnt_d   = nz_dur;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            vo_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            v1_q      <= (state_d == S1);
            v2_q      <= (state_d == S2);
            v3_q      <= (state_d == S3);
            vo_q      <= (state_d == COLLECT);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            aborted_q <= aborted_d;
        end
    end

    // NOTE: the shadow array is a small register file with reset, cleared so that no stale durations survive a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPH; k++) shd_q[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NPH; k++) shd_q[k] <= dur_in[k];
        end
    end

    assign bus.phase       = state_q;
    assign bus.valve_soln1 = v1_q;
    assign bus.valve_soln2 = v2_q;
    assign bus.valve_soln3 = v3_q;
    assign bus.valve_out   = vo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
endmodule

// File: tb/tb_soln_dispense_seq.sv
// Scoreboard bench for soln_dispense_seq. A run-plan model pushes the expected
// output of every cycle, and a negedge monitor pops and compares it.
module tb_soln_dispense_seq;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    soln_dispense_seq_if #(.CNT_W(CNT_W)) bus ();

    soln_dispense_seq #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // {phase, valve_soln1, valve_soln2, valve_soln3, valve_out, busy, done, aborted}
    logic [9:0] out_vec;
    assign out_vec = {bus.phase, bus.valve_soln1, bus.valve_soln2, bus.valve_soln3,
                      bus.valve_out, bus.busy, bus.done, bus.aborted};

    logic [9:0] sb[$];    // expected output per cycle
    int         plan[$];  // remaining phase codes of the run in progress
    int         cur = 0;  // phase the model says is showing now

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    function automatic logic [9:0] exp_vec(input int ph, input logic ab);
        logic [2:0] p;
        p = 3'(ph);
        return {p, ph == 3, ph == 1, ph == 2, ph == 5, ph != 0, ph == 6, ab};
    endfunction

    // Model: an accepted start becomes a list of phase codes, with each duration
    // repeated that many times, followed by one DONE. Abort or reset discards the list.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            plan.delete();
            cur = 0;
            sb.push_back(exp_vec(0, 1'b0));
        end else if (cur != 0 && bus.abort) begin
            plan.delete();
            cur = 0;
            sb.push_back(exp_vec(0, 1'b1));
        end else begin
            if (cur == 0 && bus.start && !bus.abort) begin
                int d[5];
                d = '{int'(bus.t_soln2), int'(bus.t_soln3), int'(bus.t_soln1),
                      int'(bus.t_settle), int'(bus.t_collect)};
                for (int k = 0; k < 5; k++) repeat (d[k]) plan.push_back(k + 1);
                plan.push_back(6);
            end
            cur = (plan.size() > 0) ? plan.pop_front() : 0;
            sb.push_back(exp_vec(cur, 1'b0));
        end
    end

    // A mid-cycle reset clears the outputs at once, so the current cycle's expectation is replaced.
    initial forever begin
        @(negedge rst_n);
        plan.delete();
        cur = 0;
        sb.delete();
        sb.push_back(exp_vec(0, 1'b0));
    end

    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            logic [9:0] e;
            e = sb.pop_front();
            check("cycle_outputs", {22'd0, out_vec}, {22'd0, e});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

    task automatic set_durs(input int a2, input int a3, input int a1, input int as, input int ac);
        bus.t_soln2   = CNT_W'(a2);
        bus.t_soln3   = CNT_W'(a3);
        bus.t_soln1   = CNT_W'(a1);
        bus.t_settle  = CNT_W'(as);
        bus.t_collect = CNT_W'(ac);
    endtask

    task automatic tick(input logic s, input logic a);
        bus.start = s;
        bus.abort = a;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_durs(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {22'd0, out_vec}, 32'd0);
        rst_n = 1'b1;

        // basic run
        set_durs(3, 2, 4, 1, 2);
        tick(1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0);

        // zero-duration phases skipped
        set_durs(1, 0, 1, 0, 1);
        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);

        // all zero goes straight to DONE
        set_durs(0, 0, 0, 0, 0);
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);

        // abort at cycle 7, restart at cycle 8
        set_durs(3, 2, 4, 1, 2);
        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0);

        // abort in IDLE, then start together with abort in IDLE
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b0);

        // start while busy, and a duration change mid-run
        set_durs(3, 2, 4, 1, 2);
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        bus.t_soln1 = CNT_W'(9);
        tick(1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0);

        // async reset in the middle of cycle 6
        set_durs(3, 2, 4, 1, 2);
        tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {22'd0, out_vec}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_durs($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                         $urandom_range(0, 3), $urandom_range(0, 5));
            end
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end
        repeat (30) tick(1'b0, 1'b0);

        // full-scale duration, no counter wrap
        set_durs(0, 0, 0, 32'hFFFF, 0);
        tick(1'b1, 1'b0);
        repeat (65540) tick(1'b0, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
